// File: rtl/if_fetch_if.sv
// if_fetch_if: fetch-stage bundle, ROM port plus IF/ID handshake and redirect inputs.
interface if_fetch_if;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic [31:0] rom_data_i;
  logic        if_valid_o;
  logic        id_ready_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_exc_o;
  modport master (
    input  stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i, rom_data_i, id_ready_i,
    output rom_addr_o, rom_ce_o, if_valid_o, if_pc_o, if_inst_o, if_exc_o
  );
  modport slave (
    output stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i, rom_data_i, id_ready_i,
    input  rom_addr_o, rom_ce_o, if_valid_o, if_pc_o, if_inst_o, if_exc_o
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: PC sequencer with 2-entry fetch buffer; IF_MISALIGN_CHK_EN enables misaligned-PC exception.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic      clk,
  input logic      rst,
  if_fetch_if.master bus
);
  typedef enum logic [1:0] {WAIT, FETCH, HALT} state_t;
  state_t           state;
  logic [31:0]      pc;
  logic [1:0]       count;
  logic             ce;
  logic [1:0][31:0] e_pc, e_inst, n_pc, n_inst;
  logic [1:0]       n_count;
  logic             pop, fire, redirect, misal, idx, valid;
  logic [31:0]      target;
  assign valid    = count != 2'd0;
  assign pop      = valid & bus.id_ready_i;
  assign redirect = bus.flush_i | (bus.branch_flag_i & state != HALT);
  assign target   = bus.flush_i ? bus.new_pc_i : bus.branch_target_i;
  assign fire     = state == FETCH & !bus.stall_i & !bus.flush_i & !bus.branch_flag_i & (count != 2'd2 | pop);
  // tail slot after this cycle's pop; only meaningful when fire is high
  assign idx      = count[1] | (count[0] & !pop);
  assign n_count  = count - {1'b0, pop} + {1'b0, fire};
`ifdef IF_MISALIGN_CHK_EN
  logic [1:0] e_exc, n_exc;
  assign misal = |pc[1:0];
  always_comb begin
    n_exc = e_exc;
    if (pop) n_exc[0] = e_exc[1];
    if (fire) n_exc[idx] = misal;
  end
  always_ff @(posedge clk)
    if (!rst && !redirect) e_exc <= n_exc;
  assign bus.if_exc_o = valid & e_exc[0];
`else
  assign misal = 1'b0;
  assign bus.if_exc_o = 1'b0;
`endif
  always_comb begin
    n_pc   = e_pc;
    n_inst = e_inst;
    if (pop) begin
      n_pc[0]   = e_pc[1];
      n_inst[0] = e_inst[1];
    end
    if (fire) begin
      n_pc[idx]   = pc;
      n_inst[idx] = misal ? 32'h0 : bus.rom_data_i;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT;
      pc    <= RESET_PC;
      ce    <= 1'b0;
      count <= 2'd0;
    end else if (redirect) begin
      state <= FETCH;
      ce    <= 1'b1;
      pc    <= target;
      count <= 2'd0;
    end else begin
      e_pc   <= n_pc;
      e_inst <= n_inst;
      count  <= n_count;
      if (state == WAIT) begin
        state <= FETCH;
        ce    <= 1'b1;
      end else if (fire && misal) begin
        state <= HALT;
        ce    <= 1'b0;
      end else if (fire) pc <= pc + 32'd4;
    end
  end
  assign bus.rom_addr_o = pc;
  assign bus.rom_ce_o   = ce;
  assign bus.if_valid_o = valid;
  assign bus.if_pc_o    = valid ? e_pc[0] : 32'h0;
  assign bus.if_inst_o  = valid ? e_inst[0] : 32'h0;
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port stall_i  input  1  hold PC, no new fetch.
REQ-005 SHALL have port flush_i  input  1  exception redirect.
REQ-006 SHALL have port new_pc_i  input  32  flush target.
REQ-007 SHALL have port branch_flag_i  input  1  branch redirect.
REQ-008 SHALL have port branch_target_i  input  32  branch target.
REQ-009 SHALL have port rom_addr_o  output  32  instruction ROM byte address (current PC).
REQ-010 SHALL have port rom_ce_o  output  1  ROM chip enable.
REQ-011 SHALL have port rom_data_i  input  32  ROM word, combinational, valid in the same cycle as rom_addr_o.
REQ-012 SHALL have port if_valid_o  output  1  buffer head valid.
REQ-013 SHALL have port id_ready_i  input  1  IF/ID accepts head.
REQ-014 SHALL have port if_pc_o  output  32  head PC.
REQ-015 SHALL have port if_inst_o  output  32  head instruction.
REQ-016 SHALL have port if_exc_o  output  1  head carries fetch-address exception.

Function
REQ-017 SHALL hold a 2-entry FIFO of {pc, inst, exc}, plus count 0..2; if_valid_o = (count != 0); head fields drive if_pc_o/if_inst_o/if_exc_o, zero when empty.
REQ-018 SHALL drive rom_addr_o = PC register; rom_ce_o is registered.
REQ-019 FSM SHALL have states WAIT (after reset, rom_ce_o=0), FETCH (rom_ce_o=1), HALT (rom_ce_o=0, exception pending).
REQ-020 WAIT -> FETCH on first edge with rst=0; PC unchanged on that edge.
REQ-021 pop = if_valid_o & id_ready_i; push (fire) = state FETCH & !stall_i & !flush_i & !branch_flag_i & (count<2 | pop).
REQ-022 On fire SHALL write {PC, rom_data_i, 0} at tail and PC <= PC+4 (32-bit wrap, 32'hFFFF_FFFC -> 0); latency fetch-to-if_valid_o = 1 cycle.
REQ-023 Simultaneous push and pop at count 2 or 1 SHALL keep count unchanged, order preserved.
REQ-024 flush_i SHALL clear count to 0, set PC <= new_pc_i, state <= FETCH (from any state), discard same-cycle ROM data; pop in that cycle still completes.
REQ-025 branch_flag_i (flush_i low) SHALL behave as REQ-024 with branch_target_i; ignored in HALT.
REQ-026 Priority: rst > flush_i > branch_flag_i > stall_i > fire.
REQ-027 stall_i SHALL not block pops; PC held.
REQ-028 Delay-slot instruction SHALL be popped by the consumer before it asserts branch_flag_i; block does not preserve it.

Reset
REQ-029 rst SHALL set PC=RESET_PC, state=WAIT, rom_ce_o=0, count=0, if_valid_o=0, if_pc_o/if_inst_o=0, if_exc_o=0; applies mid-operation, discarding all entries.

Configuration
REQ-030 Macro IF_MISALIGN_CHK_EN defined: on fire with PC[1:0]!=0 SHALL push {PC, 32'h0, 1}, not advance PC, go HALT until flush_i or rst.
REQ-031 Macro undefined: PC[1:0] ignored, exc field always 0, if_exc_o tied 0, HALT unreachable.

Verification
REQ-032 Reset release, id_ready_i=1, ROM words 0x11,0x22,0x33 -> rom_ce_o=1 one cycle after, if_pc_o 0,4,8 with those instructions on consecutive cycles.
REQ-033 id_ready_i=0 for 5 cycles -> count saturates at 2, PC stops at 8, no entry lost or duplicated when id_ready_i returns to 1.
REQ-034 branch_flag_i=1 target 0x100 with 2 entries buffered -> if_valid_o=0 next cycle, then if_pc_o=0x100.
REQ-035 flush_i and branch_flag_i same cycle, new_pc_i=0x180, target 0x100 -> next fetched pc 0x180; rst during stall -> if_valid_o=0, PC=RESET_PC.
REQ-036 With IF_MISALIGN_CHK_EN, branch target 0x102 -> entry pc 0x102, inst 0, if_exc_o=1, rom_ce_o=0 until flush_i to 0x200 resumes fetch.
